// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Program store and issue controller. It holds each word on the
//               CPU instruction bus for CPI clocks and supports run, step,
//               pause and done.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter int                     INSTR_WIDTH = 20,
    parameter int                     PROG_BITS   = 4,
    parameter int                     CPI         = 3,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_en,
    input  logic [PROG_BITS-1:0]   load_addr,
    input  logic [INSTR_WIDTH-1:0] load_data,
    input  logic [PROG_BITS-1:0]   end_addr,
    input  logic                   start,
    input  logic                   step,
    input  logic                   halt_req,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [PROG_BITS-1:0]   pc,
    output logic                   instr_valid,
    output logic                   busy,
    output logic                   done
);

    localparam int                 c_CNT_W  = (CPI > 1) ? $clog2(CPI) : 1;
    localparam int                 c_DEPTH  = 1 << PROG_BITS;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CPI - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_PAUSED = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                 r_state;
    logic [PROG_BITS-1:0]   r_pc;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [INSTR_WIDTH-1:0] r_mem [c_DEPTH];

    state_t                 w_state_nxt;
    logic [PROG_BITS-1:0]   w_pc_nxt;
    logic [PROG_BITS-1:0]   w_pc_inc;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic [INSTR_WIDTH-1:0] w_instr_nxt;
    logic                   w_we;
    logic                   w_active;

    assign w_pc_inc = r_pc + 1'b1;
    assign w_active = (r_state == S_RUN) || (r_state == S_STEP);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        w_instr_nxt = r_instr;
        w_we        = 1'b0;
        if (w_active) begin
            if (r_cnt == c_CNT_LAST) begin
                w_cnt_nxt = '0;
                if (r_pc == end_addr) begin
                    w_state_nxt = S_DONE;
                    w_instr_nxt = NOP_INSTR;
                end else if ((r_state == S_STEP) || halt_req) begin
                    w_state_nxt = S_PAUSED;
                    w_pc_nxt    = w_pc_inc;
                    w_instr_nxt = NOP_INSTR;
                end else begin
                    w_pc_nxt    = w_pc_inc;
                    w_instr_nxt = r_mem[w_pc_inc];
                end
            end else begin
                w_cnt_nxt = r_cnt + c_CNT_W'(1);
            end
        end else begin
            w_we = load_en;
            if (start) begin
                w_state_nxt = S_RUN;
                w_pc_nxt    = '0;
                w_cnt_nxt   = '0;
                w_instr_nxt = r_mem[0];
            end else if (step) begin
                // Only a paused program resumes where it stopped
                w_state_nxt = S_STEP;
                w_pc_nxt    = (r_state == S_PAUSED) ? r_pc : '0;
                w_cnt_nxt   = '0;
                w_instr_nxt = r_mem[w_pc_nxt];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_cnt   <= '0;
            r_instr <= NOP_INSTR;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_instr <= w_instr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= NOP_INSTR;
            end
        end else if (w_we) begin
            r_mem[load_addr] <= load_data;
        end
    end

    assign instruction = r_instr;
    assign pc          = r_pc;
    assign instr_valid = w_active;
    assign busy        = w_active;
    assign done        = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Directed plus randomized bench for instr_sequencer against a
//               behavioural issue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    localparam int c_CPI = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_en = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [19:0] load_data = '0;
    logic [3:0]  end_addr = '0;
    logic        start = 1'b0;
    logic        step = 1'b0;
    logic        halt_req = 1'b0;
    logic [19:0] instruction;
    logic [3:0]  pc;
    logic        instr_valid;
    logic        busy;
    logic        done;

    instr_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .end_addr    (end_addr),
        .start       (start),
        .step        (step),
        .halt_req    (halt_req),
        .instruction (instruction),
        .pc          (pc),
        .instr_valid (instr_valid),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Behavioural model: the word being issued and how many clocks it has left
    logic [19:0] m_mem [16];
    logic [19:0] m_cur;
    int          m_pc;
    int          m_left;
    bit          m_active;
    bit          m_single;
    int          m_status;   // 0 idle, 1 paused, 2 finished

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 20'h0;
        m_cur = 20'h0; m_pc = 0; m_left = 0;
        m_active = 1'b0; m_single = 1'b0; m_status = 0;
    endtask

    task automatic model_step();
        if (!m_active) begin
            if (start) begin
                m_active = 1'b1; m_single = 1'b0; m_pc = 0;
                m_cur = m_mem[0]; m_left = c_CPI;
            end else if (step) begin
                m_active = 1'b1; m_single = 1'b1;
                if (m_status != 1) m_pc = 0;
                m_cur = m_mem[m_pc]; m_left = c_CPI;
            end
            if (load_en) m_mem[load_addr] = load_data;
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (m_pc == int'(end_addr)) begin
                    m_active = 1'b0; m_status = 2;
                end else if (m_single || halt_req) begin
                    m_active = 1'b0; m_status = 1; m_pc = (m_pc + 1) % 16;
                end else begin
                    m_pc = (m_pc + 1) % 16; m_cur = m_mem[m_pc]; m_left = c_CPI;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_instruction", instruction, m_active ? m_cur : 20'h0);
            chk("m_pc", pc, 32'(m_pc));
            chk("m_instr_valid", instr_valid, m_active);
            chk("m_busy", busy, m_active);
            chk("m_done", done, (!m_active && m_status == 2));
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic load(input logic [3:0] a, input logic [19:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        cyc();
        load_en = 1'b0;
    endtask

    task automatic hold_word(input logic [19:0] w, input int p);
        for (int k = 0; k < c_CPI; k++) begin
            chk("word", instruction, w);
            chk("word_pc", pc, 32'(p));
            chk("word_valid", instr_valid, 1'b1);
            cyc();
        end
    endtask

    task automatic pulse_step();
        step = 1'b1; cyc(); step = 1'b0;
    endtask

    task automatic async_reset();
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("rst_instruction", instruction, 20'h0);
        chk("rst_pc", pc, 4'h0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [19:0] words [3];
        words[0] = 20'h11111; words[1] = 20'h22222; words[2] = 20'h33333;
        model_reset();
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("reset_instruction", instruction, 20'h0);
        chk("reset_busy", busy, 1'b0);
        rst = 1'b1;
        chk_en = 1'b1;

        // Empty program: every slot must issue NOP
        end_addr = 4'd15;
        start = 1'b1; cyc(); start = 1'b0;
        repeat (16 * c_CPI) cyc();
        chk("empty_done", done, 1'b1);
        chk("empty_pc", pc, 4'd15);

        for (int i = 0; i < 3; i++) load(4'(i), words[i]);
        end_addr = 4'd2;

        // Full run; the write to slot 1 lands while running and must be dropped
        start = 1'b1; cyc(); start = 1'b0;
        load_en = 1'b1; load_addr = 4'd1; load_data = 20'hABCDE;
        for (int i = 0; i < 9; i++) begin
            chk("run_word", instruction, words[i / 3]);
            chk("run_pc", pc, 32'(i / 3));
            cyc();
        end
        load_en = 1'b0;
        chk("run_done", done, 1'b1);
        chk("run_nop", instruction, 20'h0);
        chk("run_end_pc", pc, 4'd2);

        // Single stepping from DONE restarts at 0
        pulse_step(); hold_word(20'h11111, 0);
        chk("step1_pc", pc, 4'd1); chk("step1_valid", instr_valid, 1'b0);
        pulse_step(); hold_word(20'h22222, 1);
        chk("step2_pc", pc, 4'd2);
        pulse_step(); hold_word(20'h33333, 2);
        chk("step3_done", done, 1'b1);

        // Halt at the first boundary, then finish with halt held at the end
        halt_req = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;
        hold_word(20'h11111, 0);
        chk("halt_pc", pc, 4'd1); chk("halt_valid", instr_valid, 1'b0);
        halt_req = 1'b0;
        pulse_step(); hold_word(20'h22222, 1);
        chk("resume_pc", pc, 4'd2);
        halt_req = 1'b1;
        pulse_step(); hold_word(20'h33333, 2);
        chk("end_priority_done", done, 1'b1);
        halt_req = 1'b0;

        // Wrap: pause at 15, step through 15 and 0
        load(4'd15, 20'hF0F0F);
        load(4'd0, 20'h0A0A0);
        end_addr = 4'd15;
        start = 1'b1; cyc(); start = 1'b0;
        for (int k = 0; k < 100 && !(m_pc == 14 && m_left == 1); k++) cyc();
        halt_req = 1'b1; cyc(); halt_req = 1'b0;
        chk("wrap_pause_pc", pc, 4'd15);
        end_addr = 4'd0;
        pulse_step(); hold_word(20'hF0F0F, 15);
        chk("wrap_pc", pc, 4'd0); chk("wrap_valid", instr_valid, 1'b0);
        pulse_step(); hold_word(20'h0A0A0, 0);
        chk("wrap_done", done, 1'b1);

        // Reset in the middle of a run at cnt=1
        end_addr = 4'd15;
        start = 1'b1; cyc(); start = 1'b0; cyc();
        async_reset();

        for (int n = 0; n < 4000; n++) begin
            start     = ($urandom % 40) == 0;
            step      = ($urandom % 25) == 0;
            halt_req  = ($urandom % 4) == 0;
            load_en   = ($urandom % 5) == 0;
            load_addr = 4'($urandom);
            load_data = 20'($urandom);
            if (($urandom % 100) == 0) end_addr = 4'($urandom);
            if (($urandom % 600) == 0) async_reset();
            cyc();
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
